div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle iterative integer divider for the MIPS DIV/DIVU instructions.
- Sits in the EX stage, directly upstream of the HI/LO register.
- Accepts dividend and divisor from EX and runs one restoring-division step per clock.
- Produces {remainder, quotient}, which EX/MEM/WB carries to the HI/LO write port (HI = remainder, LO = quotient).
- EX stalls the pipeline while o_busy is high.

Parameters:
- DW, 32, operand width in bits. Must be ≥ 2; iteration count equals DW.

Ports:
- i_clk  input  1  clock; all state updates on rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_start  input  1  request a division; sampled only in IDLE
- i_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with i_start
- i_dividend  input  DW  dividend; sampled with i_start
- i_divisor  input  DW  divisor; sampled with i_start
- i_annul  input  1  cancel any operation in progress (exception/flush)
- o_busy  output  1  high in any state other than IDLE
- o_ready  output  1  one-cycle pulse: o_result valid and new
- o_result  output  2*DW  {remainder[2*DW-1:DW], quotient[DW-1:0]}; held until next completion

Behaviour:
- Clock and reset:
  - Single clock i_clk; reset i_rst_n is asynchronous, active-low.
  - During reset: state = IDLE, o_busy = 0, o_ready = 0, o_result = 0, iteration counter = 0, internal datapath = 0.
- States:
  - IDLE: i_start && !i_annul → capture operands and i_signed. If divisor == 0 → DBZ, else → RUN with counter = 0. Otherwise stay.
  - DBZ: next edge → DONE, loading o_result = 0.
  - RUN: one step per edge. Shift {partial remainder, dividend} left by 1 and trial-subtract the divisor magnitude. If no borrow, keep the difference and set quotient bit = 1; else restore and set bit = 0. Counter increments. On the step where counter == DW-1 → DONE, loading o_result with sign-corrected values.
  - DONE: o_ready = 1 for this one cycle. Next edge → IDLE unconditionally; i_start in DONE is ignored.
- Latency, with i_start sampled at edge N:
  - Normal: RUN at N..N+32 (DW = 32); o_ready high between edges N+32 and N+33.
  - Divide by zero: o_ready high between edges N+1 and N+2.
- Signed handling (i_signed = 1):
  - Operate on magnitudes.
  - Quotient negated iff dividend and divisor signs differ.
  - Remainder takes the dividend's sign and is negated iff the dividend is negative.
  - Most-negative / -1: magnitude 2^(DW-1) fits in DW unsigned bits. Result: quotient = 0x8000_0000, remainder = 0; no trap, no flag.
- Unsigned: operands used as-is, no correction.
- Annul: i_annul high in DBZ, RUN or DONE → IDLE at the next edge.
  - o_ready stays 0 in the following cycle; o_result is not updated (keeps its previous value).
  - i_annul with i_start in IDLE: annul wins, no operation starts.
- i_start while o_busy: ignored; operands not resampled.
- Operand inputs may change freely after the sampling edge.
- Asynchronous reset mid-operation: immediate return to reset values; no o_ready pulse.
- o_result changes only on entry to DONE, or on reset.

Test Plan:
- Unsigned: i_signed = 0, 100 / 7, start at edge N → o_busy high, o_ready pulse after edge N+32, o_result = {0x0000_0002, 0x0000_000E}; o_busy low after edge N+33.
- Signed mixed signs: -7 (0xFFFF_FFF9) / 2 → quotient 0xFFFF_FFFD, remainder 0xFFFF_FFFF. Also 7 / -2 → quotient 0xFFFF_FFFD, remainder 0x0000_0001.
- Divide by zero: 0x1234_5678 / 0, either i_signed → o_ready one cycle after DBZ (edge N+1), o_result = 0, total busy 2 cycles.
- Overflow corner: signed 0x8000_0000 / 0xFFFF_FFFF → quotient 0x8000_0000, remainder 0; unsigned 0xFFFF_FFFF / 1 → quotient 0xFFFF_FFFF, remainder 0.
- Annul and ignored start: preload o_result via 100 / 7.
  - Start 50 / 3, assert i_annul at RUN step 10 → o_busy low next cycle, no o_ready, o_result still {2, 14}.
  - Then pulse i_start mid-RUN with other operands → ignored; original result delivered at nominal latency.
- Reset: assert i_rst_n = 0 asynchronously mid-RUN → o_busy, o_ready, o_result = 0 immediately.
  - After release, a new 9 / 3 completes with quotient 3, remainder 0 at the normal latency.

Source files
------------

// File: rtl/div_unit.sv
// Iterative restoring divider for MIPS DIV/DIVU: one quotient bit per clock,
// result packed as {remainder, quotient} for the HI/LO write port.
module div_unit #(
    parameter int DW = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic            i_signed,
    input  logic [DW-1:0]   i_dividend,
    input  logic [DW-1:0]   i_divisor,
    input  logic            i_annul,
    output logic            o_busy,
    output logic            o_ready,
    output logic [2*DW-1:0] o_result
);

    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {IDLE, DBZ, RUN, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   rem_q;
    logic [DW-1:0]   quo_q;
    logic [DW-1:0]   dvs_q;
    logic            neg_q;
    logic            neg_r;

    logic [DW:0]     shifted;
    logic [DW:0]     diff;
    logic [DW-1:0]   step_rem;
    logic [DW-1:0]   step_quo;

    // Magnitude of a two's-complement operand; the most-negative value maps to
    // 2^(DW-1), which still fits in DW unsigned bits.
    function automatic logic [DW-1:0] magnitude(input logic [DW-1:0] v, input logic sgn);
        return (sgn && v[DW-1]) ? (~v + DW'(1)) : v;
    endfunction

    function automatic logic [DW-1:0] cond_neg(input logic [DW-1:0] v, input logic neg);
        return neg ? (~v + DW'(1)) : v;
    endfunction

    always_comb begin
        shifted  = {rem_q, quo_q[DW-1]};
        diff     = shifted - {1'b0, dvs_q};
        step_rem = diff[DW-1:0];
        step_quo = {quo_q[DW-2:0], 1'b1};
        if (diff[DW]) begin
            step_rem = shifted[DW-1:0];
            step_quo = {quo_q[DW-2:0], 1'b0};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            o_busy   <= 1'b0;
            o_ready  <= 1'b0;
            o_result <= '0;
        end else begin
            o_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start && !i_annul) begin
                        neg_q  <= i_signed & (i_dividend[DW-1] ^ i_divisor[DW-1]);
                        neg_r  <= i_signed & i_dividend[DW-1];
                        rem_q  <= '0;
                        quo_q  <= magnitude(i_dividend, i_signed);
                        dvs_q  <= magnitude(i_divisor, i_signed);
                        cnt    <= '0;
                        o_busy <= 1'b1;
                        state  <= (i_divisor == '0) ? DBZ : RUN;
                    end
                end
                DBZ: begin
                    if (i_annul) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else begin
                        state    <= DONE;
                        o_result <= '0;
                        o_ready  <= 1'b1;
                    end
                end
                RUN: begin
                    if (i_annul) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else begin
                        rem_q <= step_rem;
                        quo_q <= step_quo;
                        cnt   <= cnt + CW'(1);
                        if (cnt == CW'(DW - 1)) begin
                            state    <= DONE;
                            o_ready  <= 1'b1;
                            o_result <= {cond_neg(step_rem, neg_r), cond_neg(step_quo, neg_q)};
                        end
                    end
                end
                default: begin
                    // DONE: always return to IDLE, start requests are not sampled here
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit (DW = 32): results, latency, annul,
// ignored start and asynchronous reset.
module tb_div_unit;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_start;
    logic        i_signed;
    logic [31:0] i_dividend;
    logic [31:0] i_divisor;
    logic        i_annul;
    logic        o_busy;
    logic        o_ready;
    logic [63:0] o_result;

    int n_vec = 0;
    int n_err = 0;

    div_unit #(.DW(32)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .i_signed   (i_signed),
        .i_dividend (i_dividend),
        .i_divisor  (i_divisor),
        .i_annul    (i_annul),
        .o_busy     (o_busy),
        .o_ready    (o_ready),
        .o_result   (o_result)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    // Launch one division, wait (bounded) for o_ready, check latency and result.
    // glitch > 0 re-pulses i_start with other operands at that cycle of the run.
    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp_res,
                          input int exp_lat, input int glitch);
        int k;
        bit got;
        k   = 0;
        got = 0;
        @(negedge i_clk);
        i_signed   = sgn;
        i_dividend = a;
        i_divisor  = b;
        i_start    = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_start    = 1'b0;
        i_dividend = 32'hDEAD_BEEF;
        i_divisor  = 32'h0000_0005;
        chk({tag, ".busy"}, 64'(o_busy), 64'd1);
        while (k < 100 && !got) begin
            @(posedge i_clk);
            k++;
            @(negedge i_clk);
            if (o_ready) got = 1;
            i_start = (k == glitch) ? 1'b1 : 1'b0;
            i_signed = ~sgn;
        end
        i_start = 1'b0;
        chk({tag, ".lat"}, 64'(k), 64'(exp_lat));
        chk({tag, ".res"}, o_result, exp_res);
        @(posedge i_clk);
        @(negedge i_clk);
        chk({tag, ".idle"}, {62'd0, o_busy, o_ready}, 64'd0);
        chk({tag, ".hold"}, o_result, exp_res);
    endtask

    initial begin
        i_rst_n    = 1'b0;
        i_start    = 1'b0;
        i_signed   = 1'b0;
        i_dividend = '0;
        i_divisor  = '0;
        i_annul    = 1'b0;
        #12;
        chk("rst.state", {62'd0, o_busy, o_ready}, 64'd0);
        chk("rst.result", o_result, 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        run_op("u100_7",   1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 32, 0);
        run_op("s-7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          64'hFFFFFFFF_FFFFFFFD, 32, 0);
        run_op("s7_-2",    1'b1, 32'd7,          32'hFFFF_FFFE,  64'h00000001_FFFFFFFD, 32, 0);
        run_op("s-8_-3",   1'b1, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  64'hFFFFFFFE_00000002, 32, 0);
        run_op("dbz_u",    1'b0, 32'h1234_5678,  32'd0,          64'd0,                  1, 0);
        run_op("u100_7b",  1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 32, 0);
        run_op("dbz_s",    1'b1, 32'h1234_5678,  32'd0,          64'd0,                  1, 0);
        run_op("s_min_-1", 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  64'h00000000_80000000, 32, 0);
        run_op("u_max_1",  1'b0, 32'hFFFF_FFFF,  32'd1,          64'h00000000_FFFFFFFF, 32, 0);
        run_op("u_min_-1", 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  64'h80000000_00000000, 32, 0);

        // Annul mid-run: preload {2,14}, then cancel 50/3 at step 10
        run_op("pre",      1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 32, 0);
        @(negedge i_clk);
        i_signed   = 1'b0;
        i_dividend = 32'd50;
        i_divisor  = 32'd3;
        i_start    = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (10) @(negedge i_clk);
        chk("annul.busy_before", 64'(o_busy), 64'd1);
        i_annul = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_annul = 1'b0;
        chk("annul.state", {62'd0, o_busy, o_ready}, 64'd0);
        chk("annul.result", o_result, 64'h00000002_0000000E);
        repeat (3) @(negedge i_clk);
        chk("annul.quiet", {62'd0, o_busy, o_ready}, 64'd0);

        // Annul together with start in IDLE: nothing starts
        i_dividend = 32'd9;
        i_divisor  = 32'd2;
        i_start    = 1'b1;
        i_annul    = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
        i_annul = 1'b0;
        chk("annul_start.busy", 64'(o_busy), 64'd0);

        // Start re-pulsed mid-run with different operands is ignored
        run_op("u9_2_glitch", 1'b0, 32'd9, 32'd2, 64'h00000001_00000004, 32, 5);

        // Asynchronous reset in the middle of a run
        @(negedge i_clk);
        i_signed   = 1'b0;
        i_dividend = 32'd100;
        i_divisor  = 32'd7;
        i_start    = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (5) @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        chk("arst.state", {62'd0, o_busy, o_ready}, 64'd0);
        chk("arst.result", o_result, 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        run_op("u9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 32, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
